// File: rtl/mem_arbiter_if.sv
// Bundle of the arbiter's request, response and byte-wide RAM signals.
// The slave modport is the arbiter's view; master is the decoder/LSB/RAM side.
interface mem_arbiter_if;
    logic        rdy_in;
    logic        clear;
    logic        if_enable;
    logic [31:0] if_addr;
    logic        inst_ready;
    logic [31:0] inst;
    logic        lsb_enable;
    logic [3:0]  lsb_type;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_wdata;
    logic        lsb_ready;
    logic [31:0] lsb_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    modport slave (
        input  rdy_in, clear, if_enable, if_addr, lsb_enable, lsb_type,
               lsb_addr, lsb_wdata, mem_din, io_buffer_full,
        output inst_ready, inst, lsb_ready, lsb_rdata, mem_dout, mem_a, mem_wr
    );

    modport master (
        output rdy_in, clear, if_enable, if_addr, lsb_enable, lsb_type,
               lsb_addr, lsb_wdata, mem_din, io_buffer_full,
        input  inst_ready, inst, lsb_ready, lsb_rdata, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-wide RAM port arbiter between instruction fetch and the load/store buffer.
// Optional MEM_ARB_IO_STALL_EN holds the first byte of IO-space stores while io_buffer_full=1.
module mem_arbiter (
    input  logic         clk_in,
    input  logic         rst_in,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        STORE = 2'd3
    } state_t;

    function automatic logic [2:0] size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    size_of = 3'd1;
            2'd1:    size_of = 3'd2;
            default: size_of = 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    extend = f3[2] ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            2'd1:    extend = f3[2] ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: extend = raw;
        endcase
    endfunction

    state_t      state_r, state_n;
    logic [2:0]  cnt_r, cnt_n;
    logic [31:0] base_r, base_n;
    logic [2:0]  f3_r, f3_n;
    logic [31:0] wdata_r, wdata_n;
    logic [31:0] buf_r, buf_n;
    logic        last_lsb_r, last_lsb_n;
    logic        inst_ready_r, inst_ready_n;
    logic [31:0] inst_r, inst_n;
    logic        lsb_ready_r, lsb_ready_n;
    logic [31:0] lsb_rdata_r, lsb_rdata_n;
    logic [31:0] mem_a_r, mem_a_n;
    logic [7:0]  mem_dout_r, mem_dout_n;
    logic        wr_r, wr_n;

    logic [2:0]  size_s;
    logic [2:0]  cnt_inc_s;
    logic [1:0]  lane_s;
    logic [31:0] addr_inc_s;
    logic [31:0] word_s;
    logic        stall_s;

    assign size_s     = size_of(f3_r);
    assign cnt_inc_s  = cnt_r + 3'd1;
    assign lane_s     = cnt_r[1:0] - 2'd1;
    assign addr_inc_s = base_r + {29'd0, cnt_inc_s};

`ifdef MEM_ARB_IO_STALL_EN
    assign stall_s = (state_r == STORE) && (cnt_r == 3'd0) &&
                     (base_r[17:16] == 2'b11) && bus.io_buffer_full;
`else
    logic io_unused_s;
    assign io_unused_s = bus.io_buffer_full;
    assign stall_s     = 1'b0;
`endif

    // Read data arrives one cycle behind its address, so the byte on mem_din belongs to lane cnt-1.
    always_comb begin
        word_s = buf_r;
        if (cnt_r != 3'd0) begin
            word_s[{lane_s, 3'b000} +: 8] = bus.mem_din;
        end else begin
            word_s = buf_r;
        end
    end

    // Next-state and next-register values for the whole arbiter.
    always_comb begin
        state_n      = state_r;
        cnt_n        = cnt_r;
        base_n       = base_r;
        f3_n         = f3_r;
        wdata_n      = wdata_r;
        buf_n        = buf_r;
        last_lsb_n   = last_lsb_r;
        inst_ready_n = 1'b0;
        inst_n       = inst_r;
        lsb_ready_n  = 1'b0;
        lsb_rdata_n  = lsb_rdata_r;
        mem_a_n      = mem_a_r;
        mem_dout_n   = mem_dout_r;
        wr_n         = wr_r;
        case (state_r)
            IDLE: begin
                if (!bus.clear && (bus.lsb_enable || bus.if_enable)) begin
                    cnt_n = 3'd0;
                    buf_n = 32'd0;
                    // Round-robin on a tie: the requester not served last wins.
                    if (bus.lsb_enable && (!bus.if_enable || !last_lsb_r)) begin
                        base_n     = bus.lsb_addr;
                        f3_n       = bus.lsb_type[2:0];
                        wdata_n    = bus.lsb_wdata;
                        mem_a_n    = bus.lsb_addr;
                        last_lsb_n = 1'b1;
                        if (bus.lsb_type[3]) begin
                            state_n    = STORE;
                            wr_n       = 1'b1;
                            mem_dout_n = bus.lsb_wdata[7:0];
                        end else begin
                            state_n = LOAD;
                        end
                    end else begin
                        base_n     = bus.if_addr;
                        f3_n       = 3'd2;
                        mem_a_n    = bus.if_addr;
                        last_lsb_n = 1'b0;
                        state_n    = FETCH;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            FETCH, LOAD: begin
                if (bus.clear) begin
                    state_n = IDLE;
                    cnt_n   = 3'd0;
                    wr_n    = 1'b0;
                end else if (cnt_r == size_s) begin
                    state_n = IDLE;
                    cnt_n   = 3'd0;
                    if (state_r == FETCH) begin
                        inst_n       = word_s;
                        inst_ready_n = 1'b1;
                    end else begin
                        lsb_rdata_n = extend(word_s, f3_r);
                        lsb_ready_n = 1'b1;
                    end
                end else begin
                    buf_n   = word_s;
                    cnt_n   = cnt_inc_s;
                    mem_a_n = addr_inc_s;
                end
            end
            STORE: begin
                // Stores are issued only at commit, so clear does not abort them.
                if (stall_s) begin
                    state_n = STORE;
                end else if (cnt_r == size_s - 3'd1) begin
                    state_n     = IDLE;
                    cnt_n       = 3'd0;
                    wr_n        = 1'b0;
                    lsb_ready_n = 1'b1;
                end else begin
                    cnt_n      = cnt_inc_s;
                    mem_a_n    = addr_inc_s;
                    mem_dout_n = wdata_r[{cnt_inc_s[1:0], 3'b000} +: 8];
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 3'd0;
                wr_n    = 1'b0;
            end
        endcase
    end

    // State and output registers; everything freezes while rdy_in is low.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r      <= IDLE;
            cnt_r        <= 3'd0;
            base_r       <= 32'd0;
            f3_r         <= 3'd0;
            wdata_r      <= 32'd0;
            buf_r        <= 32'd0;
            last_lsb_r   <= 1'b0;
            inst_ready_r <= 1'b0;
            inst_r       <= 32'd0;
            lsb_ready_r  <= 1'b0;
            lsb_rdata_r  <= 32'd0;
            mem_a_r      <= 32'd0;
            mem_dout_r   <= 8'd0;
            wr_r         <= 1'b0;
        end else if (bus.rdy_in) begin
            state_r      <= state_n;
            cnt_r        <= cnt_n;
            base_r       <= base_n;
            f3_r         <= f3_n;
            wdata_r      <= wdata_n;
            buf_r        <= buf_n;
            last_lsb_r   <= last_lsb_n;
            inst_ready_r <= inst_ready_n;
            inst_r       <= inst_n;
            lsb_ready_r  <= lsb_ready_n;
            lsb_rdata_r  <= lsb_rdata_n;
            mem_a_r      <= mem_a_n;
            mem_dout_r   <= mem_dout_n;
            wr_r         <= wr_n;
        end
    end

    assign bus.inst_ready = inst_ready_r;
    assign bus.inst       = inst_r;
    assign bus.lsb_ready  = lsb_ready_r;
    assign bus.lsb_rdata  = lsb_rdata_r;
    assign bus.mem_a      = mem_a_r;
    assign bus.mem_dout   = mem_dout_r;
    assign bus.mem_wr     = wr_r & bus.rdy_in & ~stall_s;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic against a byte-array model.
// Build with or without MEM_ARB_IO_STALL_EN; the IO-store expectations follow the macro.
module tb_mem_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   wr_count;

    logic [7:0] ram       [logic [31:0]];
    logic [7:0] model_mem [logic [31:0]];

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        logic [31:0] t;
        t = a * 32'd7 + 32'h5A;
        return t[7:0];
    endfunction

    function automatic logic [7:0] rbyte(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] mbyte(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : init_byte(a);
    endfunction

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    // Little-endian value of k model bytes, sign-adjusted arithmetically when requested.
    function automatic logic [31:0] model_val(input logic [31:0] a, input int k, input bit sgn);
        longint v;
        v = 0;
        for (int i = k - 1; i >= 0; i--) v = v * 256 + longint'(mbyte(a + 32'(i)));
        if (sgn && v >= (64'sd1 <<< (8 * k - 1))) v = v - (64'sd1 <<< (8 * k));
        return v[31:0];
    endfunction

    // Synchronous byte RAM: read data appears the cycle after its address.
    always @(posedge clk) begin
        bus.mem_din <= rbyte(bus.mem_a);
        if (bus.mem_wr === 1'b1) begin
            ram[bus.mem_a] = bus.mem_dout;
            wr_count++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_store(input logic [31:0] a, input int k, input logic [31:0] wd);
        for (int i = 0; i < k; i++) model_mem[a + 32'(i)] = wd[8 * i +: 8];
    endtask

    function automatic logic [31:0] ram_word(input logic [31:0] a, input int k);
        logic [31:0] w;
        w = 32'd0;
        for (int i = 0; i < k; i++) w[8 * i +: 8] = rbyte(a + 32'(i));
        return w;
    endfunction

    // Issue one request at a negedge and wait for its ready pulse, with optional clear/freeze/IO events.
    task automatic run_txn(input bit is_lsb, input logic [3:0] typ, input logic [31:0] addr,
                           input logic [31:0] wd, input int clr_at, input int frz_at,
                           input int frz_len, input int io_clr_at,
                           output logic [31:0] data, output int lat, output int wrs);
        int  w0;
        logic got;
        w0  = wr_count;
        lat = 0;
        got = 1'b0;
        if (is_lsb) begin
            bus.lsb_enable = 1'b1;
            bus.lsb_type   = typ;
            bus.lsb_addr   = addr;
            bus.lsb_wdata  = wd;
        end else begin
            bus.if_enable = 1'b1;
            bus.if_addr   = addr;
        end
        while (!got && lat < 60) begin
            @(negedge clk);
            lat++;
            got = is_lsb ? bus.lsb_ready : bus.inst_ready;
            if (!got) begin
                bus.clear  = (lat == clr_at);
                bus.rdy_in = !(frz_len > 0 && lat >= frz_at && lat < frz_at + frz_len);
                if (lat == io_clr_at) bus.io_buffer_full = 1'b0;
            end
        end
        chk("ready_seen", {31'd0, got}, 32'd1);
        data           = is_lsb ? bus.lsb_rdata : bus.inst;
        bus.lsb_enable = 1'b0;
        bus.if_enable  = 1'b0;
        bus.clear      = 1'b0;
        bus.rdy_in     = 1'b1;
        wrs            = wr_count - w0;
    endtask

    logic [31:0] d;
    int          lat;
    int          wrs;
    bit          order [$];
    bit          exp_order [4];
    logic [2:0]  loads  [5];
    logic [2:0]  stores [3];

    initial begin
        checks = 0;
        errors = 0;
        wr_count = 0;
        loads  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        stores = '{3'd0, 3'd1, 3'd2};
        rst = 1'b1;
        bus.rdy_in = 1'b1;
        bus.clear = 1'b0;
        bus.if_enable = 1'b0;
        bus.if_addr = 32'd0;
        bus.lsb_enable = 1'b0;
        bus.lsb_type = 4'd0;
        bus.lsb_addr = 32'd0;
        bus.lsb_wdata = 32'd0;
        bus.io_buffer_full = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_inst_ready", {31'd0, bus.inst_ready}, 32'd0);
        chk("rst_lsb_ready", {31'd0, bus.lsb_ready}, 32'd0);
        chk("rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
        chk("rst_mem_a", bus.mem_a, 32'd0);
        chk("rst_inst", bus.inst, 32'd0);

        // Round-robin from reset with both requesters held high: LSB first, then alternating
        bus.if_enable  = 1'b1;
        bus.if_addr    = 32'h100;
        bus.lsb_enable = 1'b1;
        bus.lsb_type   = 4'b0010;
        bus.lsb_addr   = 32'h20;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 60 && order.size() < 4; c++) begin
            @(negedge clk);
            if (bus.lsb_ready) order.push_back(1'b1);
            if (bus.inst_ready) order.push_back(1'b0);
        end
        bus.if_enable  = 1'b0;
        bus.lsb_enable = 1'b0;
        exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
        chk("rr_count", 32'(order.size()), 32'd4);
        for (int i = 0; i < 4 && i < order.size(); i++)
            chk($sformatf("rr_grant%0d", i), {31'd0, order[i]}, {31'd0, exp_order[i]});
        repeat (2) @(negedge clk);

        // Fetch of a word stored through the arbiter
        run_txn(1'b1, 4'b1010, 32'h100, 32'h00A00513, 0, 0, 0, 0, d, lat, wrs);
        model_store(32'h100, 4, 32'h00A00513);
        run_txn(1'b0, 4'd0, 32'h100, 32'd0, 0, 0, 0, 0, d, lat, wrs);
        chk("fetch_inst", d, 32'h00A00513);
        chk("fetch_latency", 32'(lat), 32'd6);

        // Byte / half loads with sign and zero extension
        run_txn(1'b1, 4'b1000, 32'h20, 32'h00000080, 0, 0, 0, 0, d, lat, wrs);
        model_store(32'h20, 1, 32'h80);
        run_txn(1'b1, 4'b0000, 32'h20, 32'd0, 0, 0, 0, 0, d, lat, wrs);
        chk("lb_data", d, 32'hFFFFFF80);
        chk("lb_latency", 32'(lat), 32'd3);
        run_txn(1'b1, 4'b0100, 32'h20, 32'd0, 0, 0, 0, 0, d, lat, wrs);
        chk("lbu_data", d, 32'h00000080);
        run_txn(1'b1, 4'b1001, 32'h24, 32'h00009234, 0, 0, 0, 0, d, lat, wrs);
        model_store(32'h24, 2, 32'h9234);
        run_txn(1'b1, 4'b0001, 32'h24, 32'd0, 0, 0, 0, 0, d, lat, wrs);
        chk("lh_data", d, 32'hFFFF9234);
        chk("lh_latency", 32'(lat), 32'd4);

        // Word store and read-back
        run_txn(1'b1, 4'b1010, 32'h40, 32'hDEADBEEF, 0, 0, 0, 0, d, lat, wrs);
        model_store(32'h40, 4, 32'hDEADBEEF);
        chk("sw_writes", 32'(wrs), 32'd4);
        chk("sw_latency", 32'(lat), 32'd5);
        chk("sw_bytes", ram_word(32'h40, 4), 32'hDEADBEEF);
        run_txn(1'b1, 4'b0010, 32'h40, 32'd0, 0, 0, 0, 0, d, lat, wrs);
        chk("lw_readback", d, 32'hDEADBEEF);

        // Clear at cnt=2 aborts the fetch; the held request is regranted once clear drops
        run_txn(1'b0, 4'd0, 32'h100, 32'd0, 3, 0, 0, 0, d, lat, wrs);
        chk("clr_fetch_latency", 32'(lat), 32'd10);
        chk("clr_fetch_inst", d, 32'h00A00513);

        // Clear during a store does not stop it
        run_txn(1'b1, 4'b1010, 32'h50, 32'h11223344, 2, 0, 0, 0, d, lat, wrs);
        model_store(32'h50, 4, 32'h11223344);
        chk("clr_sw_writes", 32'(wrs), 32'd4);
        chk("clr_sw_latency", 32'(lat), 32'd5);
        chk("clr_sw_bytes", ram_word(32'h50, 4), 32'h11223344);

        // rdy_in low for three cycles freezes a halfword store
        run_txn(1'b1, 4'b1001, 32'h61, 32'h0000A55A, 0, 1, 3, 0, d, lat, wrs);
        model_store(32'h61, 2, 32'hA55A);
        chk("frz_sh_writes", 32'(wrs), 32'd2);
        chk("frz_sh_latency", 32'(lat), 32'd6);
        chk("frz_sh_bytes", ram_word(32'h61, 2), 32'h0000A55A);

        // IO-space byte store with the UART buffer full for five cycles
        bus.io_buffer_full = 1'b1;
        run_txn(1'b1, 4'b1000, 32'h30000, 32'h0000003C, 0, 0, 0, 5, d, lat, wrs);
        bus.io_buffer_full = 1'b0;
        model_store(32'h30000, 1, 32'h3C);
        chk("io_sb_writes", 32'(wrs), 32'd1);
`ifdef MEM_ARB_IO_STALL_EN
        chk("io_sb_latency", 32'(lat), 32'd6);
`else
        chk("io_sb_latency", 32'(lat), 32'd2);
`endif
        chk("io_sb_byte", {24'd0, rbyte(32'h30000)}, 32'h3C);

        // Asynchronous reset in the middle of a load
        bus.lsb_enable = 1'b1;
        bus.lsb_type   = 4'b0010;
        bus.lsb_addr   = 32'h44;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("amid_rst_mem_a", bus.mem_a, 32'd0);
        chk("amid_rst_lsb_rdata", bus.lsb_rdata, 32'd0);
        chk("amid_rst_inst", bus.inst, 32'd0);
        chk("amid_rst_ready", {30'd0, bus.lsb_ready, bus.inst_ready}, 32'd0);
        bus.lsb_enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Random traffic against the byte-array model
        for (int n = 0; n < 30; n++) begin
            int          op;
            int          k;
            logic [31:0] a;
            logic [31:0] wd;
            logic [31:0] exp;
            logic [2:0]  f3;
            op  = $urandom_range(0, 2);
            a   = 32'($urandom_range(0, 300));
            wd  = $urandom;
            if (op == 0) begin
                exp = model_val(a, 4, 1'b0);
                run_txn(1'b0, 4'd0, a, 32'd0, 0, 0, 0, 0, d, lat, wrs);
                chk($sformatf("rnd%0d_fetch", n), d, exp);
                chk($sformatf("rnd%0d_lat", n), 32'(lat), 32'd6);
                chk($sformatf("rnd%0d_wrs", n), 32'(wrs), 32'd0);
            end else if (op == 1) begin
                f3  = loads[$urandom_range(0, 4)];
                k   = size_of(f3);
                exp = model_val(a, k, !f3[2]);
                run_txn(1'b1, {1'b0, f3}, a, 32'd0, 0, 0, 0, 0, d, lat, wrs);
                chk($sformatf("rnd%0d_load", n), d, exp);
                chk($sformatf("rnd%0d_lat", n), 32'(lat), 32'(k + 2));
                chk($sformatf("rnd%0d_wrs", n), 32'(wrs), 32'd0);
            end else begin
                f3 = stores[$urandom_range(0, 2)];
                k  = size_of(f3);
                run_txn(1'b1, {1'b1, f3}, a, wd, 0, 0, 0, 0, d, lat, wrs);
                model_store(a, k, wd);
                chk($sformatf("rnd%0d_lat", n), 32'(lat), 32'(k + 1));
                chk($sformatf("rnd%0d_wrs", n), 32'(wrs), 32'(k));
                chk($sformatf("rnd%0d_bytes", n), ram_word(a, k), model_val(a, k, 1'b0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single byte-wide RAM port between the decoder's instruction fetch and the load/store buffer. Each accepted request is sequenced as a burst of byte accesses. Read bytes are assembled and sign/zero-extended, and one-cycle completion pulses are returned to the requester. The block sits between the decoder/LSB and the external RAM. It honours pipeline clear by aborting speculative reads.

## Interface
- `clk_in` input 1: system clock.
- `rst_in` input 1: asynchronous active-high reset.
- `rdy_in` input 1: global ready; when low, all state freezes.
- `clear` input 1: misprediction flush.
- `if_enable` input 1: fetch request from the decoder; level, held until served.
- `if_addr` input 32: fetch address.
- `inst_ready` output 1: one-cycle pulse; `inst` is valid.
- `inst` output 32: fetched word, little-endian.
- `lsb_enable` input 1: load/store request; level, held until served.
- `lsb_type` input 4: bit3 = store; bits[2:0] = funct3 (0 b, 1 h, 2 w, 4 bu, 5 hu).
- `lsb_addr` input 32: access address.
- `lsb_wdata` input 32: store data; the low `size` bytes are used.
- `lsb_ready` output 1: one-cycle pulse; load data valid or store done.
- `lsb_rdata` output 32: extended load result.
- `mem_din` input 8: RAM read byte.
- `mem_dout` output 8: RAM write byte.
- `mem_a` output 32: RAM byte address.
- `mem_wr` output 1: write strobe, gated combinationally with `rdy_in`.
- `io_buffer_full` input 1: UART buffer full (see Configuration).

## Operation
- States:
  - IDLE
  - FETCH: 4-byte read.
  - LOAD: 1/2/4-byte read.
  - STORE: 1/2/4-byte write.
- Size is 1 for funct3[1:0]=0, 2 for funct3[1:0]=1, and 4 otherwise.
- IDLE grant rules:
  - If only one requester is active, grant it.
  - If both are active, round-robin: grant the requester not served last. After reset the last-served requester is fetch, so LSB wins the first tie.
  - A request is not granted in a cycle where `clear`=1.
- On grant, latch the address, type and wdata; set byte counter `cnt`=0; drive `mem_a`=base.
- Read states:
  - `mem_din` in cycle t holds the byte addressed by `mem_a` in cycle t-1.
  - The block drives `mem_a`=base+`cnt` and captures `mem_din` into byte lane `cnt`-1.
  - When the last lane is captured:
    - extend the result: `lh`/`lb` sign-extend from bit 15/7; `lhu`/`lbu` zero-extend;
    - register the result and pulse the ready output;
    - return to IDLE.
- STORE: each cycle drive `mem_wr`=1, `mem_a`=base+`cnt`, `mem_dout`=`wdata`[8·`cnt`+7:8·`cnt`]. After `size` cycles, pulse `lsb_ready` and return to IDLE.
- Address arithmetic: 32-bit wrap-around with no alignment check. Misaligned accesses are performed bytewise.
- `clear`:
  - FETCH or LOAD in progress: abort immediately to IDLE; no ready pulse; `mem_wr`=0.
  - STORE in progress: runs to completion, since stores are only issued at commit.
  - A ready pulse already registered in the `clear` cycle is still delivered; the requester discards it.
- `rdy_in`=0: counters, state and registered outputs hold; `mem_wr` reads 0.
- Reset, asynchronous, mid-burst included: state IDLE; all outputs 0; `cnt`=0; last-served = fetch.

## Timing
- Grant edge E0 in IDLE.
- Read of k bytes:
  - bytes are captured at edges E2..E(k+1);
  - the ready pulse is high in the cycle after E(k+1);
  - latency is k+2 cycles from request-visible to ready (fetch: 6).
- Store of k bytes:
  - writes occur in the cycles after E0..E(k-1);
  - `lsb_ready` is high in the cycle after Ek.
- A new grant is possible at the edge on which the ready pulse is registered plus one, i.e. the block is back in IDLE during the ready cycle. It may grant in that cycle if `clear`=0.
- The requester must drop or change its request on the cycle it sees ready. A request still high in the ready cycle is treated as a new request.

## Configuration
- `MEM_ARB_IO_STALL_EN` defined:
  - a STORE whose base address has bits[17:16]=2'b11 (IO space) does not issue its first byte while `io_buffer_full`=1;
  - the state holds at `cnt`=0 with `mem_wr`=0 until the input clears;
  - subsequent bytes are not stalled.
- Undefined: `io_buffer_full` is ignored, and IO stores proceed like normal stores.

## Test plan
- Fetch only: `if_addr`=0x100, RAM[0x100..0x103]=13 05 A0 00 -> `inst`=0x00A00513, `inst_ready` pulse 6 cycles after request.
- Load `lb` at 0x20 with byte 0x80 -> `lsb_rdata`=0xFFFFFF80; `lbu` on the same address -> 0x00000080; `lh` of bytes 0x34,0x92 -> 0xFFFF9234.
- Store `sw` 0xDEADBEEF at 0x40 -> `mem_wr` high 4 cycles, bytes EF BE AD DE at 0x40..0x43; `lsb_ready` pulse; read-back by `lw` returns 0xDEADBEEF.
- Both requesters held high from reset -> grants alternate LSB, fetch, LSB, fetch.
- `clear` asserted during FETCH at `cnt`=2 -> no `inst_ready`, IDLE next cycle, new fetch at the flushed address served normally. `clear` during STORE -> all 4 bytes still written and `lsb_ready` pulses.
- With `MEM_ARB_IO_STALL_EN`: `sb` to 0x30000 while `io_buffer_full`=1 for 5 cycles -> `mem_wr` stays 0 for those cycles, then writes once, then `lsb_ready`. `rst_in` pulsed mid-load -> all outputs 0 immediately.
